// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Turns the byte stream from the PS/2 receive FSM into Set-2 key events.
// It resolves the E0 extended prefix and the F0 break prefix, swallows the
// 8-byte Pause sequence (E1 + 7 bytes), and drops controller status bytes.
// Decoded events are queued in a show-ahead FIFO with a valid/ready handshake.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx_done     one-cycle strobe, rx_data holds a new byte
//   rx_data     received byte
//   key_valid   FIFO non-empty, head event presented
//   key_code    head event scan code (8'h00 when empty)
//   key_break   head event is a release
//   key_ext     head event is extended
//   key_ready   consumer accepts the head event when key_valid=1
//   overflow    one-cycle registered pulse: a completed event was dropped
//   fifo_count  number of queued events
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_done,
    input  logic [7:0]                  rx_data,
    output logic                        key_valid,
    output logic [7:0]                  key_code,
    output logic                        key_break,
    output logic                        key_ext,
    input  logic                        key_ready,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    // Controller status / acknowledge bytes that never form part of a key event.
    function automatic logic is_status(input logic [7:0] b);
        logic hit;
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: hit = 1'b1;
            default:                    hit = 1'b0;
        endcase
        return hit;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [2:0]      skip_r;
    logic [2:0]      skip_nxt_s;
    logic            push_s;
    logic [9:0]      push_ev_s;

    logic [9:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;
    logic            pop_s;
    logic            accept_s;
    logic            drop_s;

    // Decoder next-state: only advances on rx_done; events are {ext, brk, code}.
    always_comb begin
        state_nxt_s = state_r;
        skip_nxt_s  = skip_r;
        push_s      = 1'b0;
        push_ev_s   = 10'h000;
        if (rx_done) begin
            if (state_r == ST_PAUSE) begin
                // Pause bytes are counted, never interpreted or filtered.
                if (skip_r <= 3'd1) begin
                    push_s      = 1'b1;
                    push_ev_s   = {1'b0, 1'b0, 8'hE1};
                    skip_nxt_s  = 3'd0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    skip_nxt_s = skip_r - 3'd1;
                end
            end else if (is_status(rx_data)) begin
                // Status byte abandons any pending prefix.
                state_nxt_s = ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        case (rx_data)
                            8'hE0: state_nxt_s = ST_EXT;
                            8'hF0: state_nxt_s = ST_BRK;
                            8'hE1: begin
                                state_nxt_s = ST_PAUSE;
                                skip_nxt_s  = 3'd7;
                            end
                            default: begin
                                push_s    = 1'b1;
                                push_ev_s = {1'b0, 1'b0, rx_data};
                            end
                        endcase
                    end
                    ST_EXT: begin
                        case (rx_data)
                            8'hF0: state_nxt_s = ST_EXT_BRK;
                            8'hE0: state_nxt_s = ST_EXT;
                            default: begin
                                push_s      = 1'b1;
                                push_ev_s   = {1'b1, 1'b0, rx_data};
                                state_nxt_s = ST_IDLE;
                            end
                        endcase
                    end
                    ST_BRK: begin
                        case (rx_data)
                            8'hE0: state_nxt_s = ST_EXT_BRK;
                            8'hF0: state_nxt_s = ST_BRK;
                            default: begin
                                push_s      = 1'b1;
                                push_ev_s   = {1'b0, 1'b1, rx_data};
                                state_nxt_s = ST_IDLE;
                            end
                        endcase
                    end
                    ST_EXT_BRK: begin
                        case (rx_data)
                            8'hE0, 8'hF0: state_nxt_s = ST_EXT_BRK;
                            default: begin
                                push_s      = 1'b1;
                                push_ev_s   = {1'b1, 1'b1, rx_data};
                                state_nxt_s = ST_IDLE;
                            end
                        endcase
                    end
                    default: state_nxt_s = ST_IDLE;
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Decoder state and pause skip counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            skip_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            skip_r  <= skip_nxt_s;
        end
    end

    assign key_valid = (count_r != CW'(0));
    assign pop_s     = key_valid && key_ready;
    // A full queue still takes the new event when the head leaves this cycle.
    assign accept_s  = push_s && ((count_r != CW'(FIFO_DEPTH)) || pop_s);
    assign drop_s    = push_s && !accept_s;

    // FIFO pointers, occupancy and registered overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            overflow_r <= drop_s;
        end
    end

    // Event storage; contents are don't-care until counted as valid.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= push_ev_s;
        end
    end

    // Show-ahead head outputs, forced to zero while the queue is empty.
    always_comb begin
        if (key_valid) begin
            {key_ext, key_break, key_code} = mem_r[rd_ptr_r];
        end else begin
            {key_ext, key_break, key_code} = 10'h000;
        end
    end

    assign overflow   = overflow_r;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Table-driven bench for ps2_scancode_decoder (FIFO_DEPTH=4).
// Each record is one clock cycle: inputs driven at the falling edge,
// outputs compared 1 ns after the following rising edge.
module tb_ps2_scancode_decoder;

    logic       clk;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       key_ready;
    logic       overflow;
    logic [2:0] fifo_count;

    ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_break  (key_break),
        .key_ext    (key_ext),
        .key_ready  (key_ready),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rx;
        logic [7:0] data;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_code;
        logic       e_brk;
        logic       e_ext;
        logic [2:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_applied;
    int   n_fail;

    task automatic add(input logic r, input logic rx, input logic [7:0] d, input logic rdy,
                       input logic ev, input logic [7:0] ec, input logic eb, input logic ee,
                       input logic [2:0] ecnt, input logic eo);
        vec_t v;
        v.rst = r; v.rx = rx; v.data = d; v.rdy = rdy;
        v.e_valid = ev; v.e_code = ec; v.e_brk = eb; v.e_ext = ee;
        v.e_cnt = ecnt; v.e_ovf = eo;
        vecs.push_back(v);
    endtask

    // Byte in, no pop, queue still empty afterwards.
    task automatic add_nop(input logic [7:0] d);
        add(1'b0, 1'b1, d, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    // Idle cycle popping the single queued event.
    task automatic add_pop_empty();
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic apply(input vec_t v, input string name);
        logic [14:0] got;
        logic [14:0] exp;
        @(negedge clk);
        rst       = v.rst;
        rx_done   = v.rx;
        rx_data   = v.data;
        key_ready = v.rdy;
        @(posedge clk);
        #1;
        got = {key_valid, key_code, key_break, key_ext, fifo_count, overflow};
        exp = {v.e_valid, v.e_code, v.e_brk, v.e_ext, v.e_cnt, v.e_ovf};
        n_applied++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%b code=%h brk=%b ext=%b cnt=%0d ovf=%b, want v=%b code=%h brk=%b ext=%b cnt=%0d ovf=%b",
                     name, got[14], got[13:6], got[5], got[4], got[3:1], got[0],
                     exp[14], exp[13:6], exp[5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    initial begin
        vec_t h;
        n_applied = 0;
        n_fail    = 0;
        rst       = 1'b1;
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        key_ready = 1'b0;

        // reset state
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        // plain make code, then pop
        add(1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 3'd1, 1'b0);
        add_pop_empty();
        // E0 F0 75 spaced out
        add_nop(8'hE0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        add_nop(8'hF0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        add(1'b0, 1'b1, 8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 3'd1, 1'b0);
        add_pop_empty();
        // E0 F0 75 back-to-back
        add_nop(8'hE0);
        add_nop(8'hF0);
        add(1'b0, 1'b1, 8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 3'd1, 1'b0);
        // F0 E0 75, first byte arrives while the previous event is popped
        add(1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        add_nop(8'hE0);
        add(1'b0, 1'b1, 8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 3'd1, 1'b0);
        add_pop_empty();
        // Pause sequence: one event on the eighth byte only
        add_nop(8'hE1);
        add_nop(8'h14);
        add_nop(8'h77);
        add_nop(8'hE1);
        add_nop(8'hF0);
        add_nop(8'h14);
        add_nop(8'hF0);
        add(1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 8'hE1, 1'b0, 1'b0, 3'd1, 1'b0);
        add_pop_empty();
        // E0 FA 1C: status byte abandons prefix
        add_nop(8'hE0);
        add_nop(8'hFA);
        add(1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 3'd1, 1'b0);
        // standalone AA while popping
        add(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        // F0 FF 1C: break prefix abandoned too
        add_nop(8'hF0);
        add_nop(8'hFF);
        add(1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 3'd1, 1'b0);
        add_pop_empty();
        // repeated prefixes: E0 E0 6B and F0 F0 6B
        add_nop(8'hE0);
        add_nop(8'hE0);
        add(1'b0, 1'b1, 8'h6B, 1'b0, 1'b1, 8'h6B, 1'b0, 1'b1, 3'd1, 1'b0);
        add_pop_empty();
        add_nop(8'hF0);
        add_nop(8'hF0);
        add(1'b0, 1'b1, 8'h6B, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b0, 3'd1, 1'b0);
        add_pop_empty();
        // key_ready on an empty queue is ignored
        add_pop_empty();
        // overflow: five pushes into a four-deep queue
        add(1'b0, 1'b1, 8'h16, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd1, 1'b0);
        add(1'b0, 1'b1, 8'h1E, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd2, 1'b0);
        add(1'b0, 1'b1, 8'h26, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd3, 1'b0);
        add(1'b0, 1'b1, 8'h25, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b0, 1'b1, 8'h2E, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd4, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h1E, 1'b0, 1'b0, 3'd3, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h26, 1'b0, 1'b0, 3'd2, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h25, 1'b0, 1'b0, 3'd1, 1'b0);
        add_pop_empty();
        // full queue with a pop on the fifth push: accepted, no overflow
        add(1'b0, 1'b1, 8'h16, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd1, 1'b0);
        add(1'b0, 1'b1, 8'h1E, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd2, 1'b0);
        add(1'b0, 1'b1, 8'h26, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd3, 1'b0);
        add(1'b0, 1'b1, 8'h25, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b0, 1'b1, 8'h2E, 1'b1, 1'b1, 8'h1E, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h26, 1'b0, 1'b0, 3'd3, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h25, 1'b0, 1'b0, 3'd2, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h2E, 1'b0, 1'b0, 3'd1, 1'b0);
        add_pop_empty();

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Hand sequence: reset after E0 with two events queued; rx_done during
        // rst is ignored, and the following 1C decodes without the lost prefix.
        h = '{1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 3'd1, 1'b0};
        apply(h, "rst_q1");
        h = '{1'b0, 1'b1, 8'h24, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 3'd2, 1'b0};
        apply(h, "rst_q2");
        h = '{1'b0, 1'b1, 8'hE0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 3'd2, 1'b0};
        apply(h, "rst_pref");
        h = '{1'b1, 1'b1, 8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
        apply(h, "rst_flush");
        h = '{1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 3'd1, 1'b0};
        apply(h, "rst_after");

        // Hand sequence: rx_data wiggling without rx_done must not be decoded.
        for (int k = 0; k < 3; k++) begin
            h = '{1'b0, 1'b0, 8'h3A, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 3'd1, 1'b0};
            apply(h, $sformatf("no_strobe%0d", k));
        end
        h = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
        apply(h, "final_pop");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
